// File: rtl/vga_pkg.sv
// Shared timing constants, types and address helper for the VGA scanout block.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_pkg;

  typedef logic [9:0]  cnt_t;
  typedef logic [2:0]  rgb3_t;
  typedef logic [16:0] fb_addr_t;

  // 640x480@60 timing, in pixel clocks (horizontal) and lines (vertical)
  localparam cnt_t H_VIS  = 10'd640;
  localparam cnt_t H_FP   = 10'd16;
  localparam cnt_t H_SYNC = 10'd96;
  localparam cnt_t H_BP   = 10'd48;
  localparam cnt_t V_VIS  = 10'd480;
  localparam cnt_t V_FP   = 10'd10;
  localparam cnt_t V_SYNC = 10'd2;
  localparam cnt_t V_BP   = 10'd33;

  localparam cnt_t H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800
  localparam cnt_t V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525
  localparam cnt_t H_MAX   = H_TOTAL - 10'd1;
  localparam cnt_t V_MAX   = V_TOTAL - 10'd1;

  localparam cnt_t HS_START = H_VIS + H_FP;                 // 656
  localparam cnt_t HS_END   = H_VIS + H_FP + H_SYNC;        // 752
  localparam cnt_t VS_START = V_VIS + V_FP;                 // 490
  localparam cnt_t VS_END   = V_VIS + V_FP + V_SYNC;        // 492

  // Frame buffer geometry: half resolution, every pixel doubled on screen
  localparam logic [8:0] FB_W     = 9'd320;
  localparam logic [7:0] FB_H     = 8'd240;
  localparam int         FB_DEPTH = 76800;
  localparam int         FB_AW    = 17;

  // Sync/visible flags travelling down the output pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // row*320 + col, built from shifts so no multiplier is needed
  function automatic fb_addr_t fb_addr(input logic [8:0] col, input logic [7:0] row);
    return {1'b0, row, 8'b0} + {3'b0, row, 6'b0} + {8'b0, col};
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel-write bus from the drawing FSM into the scanout frame buffer.
// Latency: the write lands in RAM on the clk edge that samples writeEn.
// Backpressure: none; every strobe is accepted (out-of-range ones are dropped).
interface vga_scanout_if;
  import vga_pkg::*;

  logic [8:0] x;
  logic [7:0] y;
  rgb3_t      color;
  logic       writeEn;

  modport master (output x, y, color, writeEn);
  modport slave  (input  x, y, color, writeEn);

endinterface

// File: rtl/vga_framebuffer.sv
// 76800x3 simple dual-port frame buffer: one write port, one registered read port.
// Latency: read data valid 1 clk after a cycle with re=1.
// Backpressure: none; read-during-write to one address returns the old data.
module vga_framebuffer
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     we,
  input  fb_addr_t wr_addr,
  input  rgb3_t    wr_dat,
  input  logic     re,
  input  fb_addr_t rd_addr,
  output rgb3_t    rd_dat
);

  rgb3_t mem [0:FB_DEPTH-1];

  // Single clocked process so the tool maps it to block RAM with old-data read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_dat;
    end
    if (re) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// 320x240 frame buffer scanned out as 640x480@60 VGA with 2x pixel doubling.
// Latency: counter position to pins is 2 pixel clocks (4 clk); writes take 1 clk.
// Backpressure: none; pixel writes are always accepted, out-of-range ones dropped.
module vga_scanout
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              iReset,
  vga_scanout_if.slave      wr,
  output logic              V_SYNC,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  logic     pix_en;
  cnt_t     h_count;
  cnt_t     v_count;
  sync_t    sync_now;
  sync_t    sync_d1;
  sync_t    sync_d2;
  rgb3_t    rd_dat;
  rgb3_t    rgb_q;
  logic     wr_ok;
  fb_addr_t wr_addr;
  fb_addr_t rd_addr;

  // 25 MHz pixel enable: toggles every clk, counters move on the high phase
  always_ff @(posedge clk) begin
    if (iReset) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end

  // Raster counters: hCount 0..799, vCount steps on hCount wrap and runs 0..524
  always_ff @(posedge clk) begin
    if (iReset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en) begin
      if (h_count == H_MAX) begin
        h_count <= '0;
        if (v_count == V_MAX) begin
          v_count <= '0;
        end else begin
          v_count <= v_count + 10'd1;
        end
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  // Sync and visible decode straight off the counters (sync pulses active low)
  assign sync_now = '{
    hs:  !((h_count >= HS_START) && (h_count < HS_END)),
    vs:  !((v_count >= VS_START) && (v_count < VS_END)),
    vis: (h_count < H_VIS) && (v_count < V_VIS)
  };

  // Halving the counters repeats each stored pixel over a 2x2 screen block.
  // Outside the visible region v_count>>1 exceeds 8 bits, but re is gated there.
  assign rd_addr = fb_addr(h_count[9:1], v_count[8:1]);

  assign wr_ok   = wr.writeEn && (wr.x < FB_W) && (wr.y < FB_H);
  assign wr_addr = fb_addr(wr.x, wr.y);

  vga_framebuffer u_fb (
    .clk     (clk),
    .we      (wr_ok),
    .wr_addr (wr_addr),
    .wr_dat  (wr.color),
    .re      (pix_en && sync_now.vis),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // Stage 1 holds flags alongside the RAM read; stage 2 drives the pins
  always_ff @(posedge clk) begin
    if (iReset) begin
      sync_d1 <= SYNC_IDLE;
      sync_d2 <= SYNC_IDLE;
      rgb_q   <= '0;
    end else if (pix_en) begin
      sync_d1 <= sync_now;
      sync_d2 <= sync_d1;
      rgb_q   <= sync_d1.vis ? rd_dat : 3'b000;
    end
  end

  assign VGA_CLK     = pix_en;
  assign VGA_HS      = sync_d2.hs;
  assign VGA_VS      = sync_d2.vs;
  assign V_SYNC      = sync_d2.vs;
  assign VGA_BLANK_N = sync_d2.vis;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset state, pixel doubling, range drops, sync timing.
// Latency: screen index n = v*800+h appears on the pins 4+2n clk after reset release.
// Backpressure: none exercised; the write bus is driven freely.
`timescale 1ns/1ps
module tb_vga_scanout;

  logic       clk = 1'b0;
  logic       iReset;
  logic       V_SYNC, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_scanout_if wr_bus ();

  vga_scanout dut (
    .clk         (clk),
    .iReset      (iReset),
    .wr          (wr_bus),
    .V_SYNC      (V_SYNC),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #10 clk = ~clk;

  localparam int FRAME_PX = 420000;
  localparam int WIN_END  = 4 + 2 * FRAME_PX;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // clk edges since reset release (edge P0 takes it to 1)
  always @(posedge clk) begin
    if (iReset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr_pix(input int px, input int py, input logic [2:0] c);
    wr_bus.x       = px[8:0];
    wr_bus.y       = py[7:0];
    wr_bus.color   = c;
    wr_bus.writeEn = 1'b1;
    @(negedge clk);
    wr_bus.writeEn = 1'b0;
  endtask

  function automatic int pin_cyc(input int h, input int v, input int frame);
    return 4 + 2 * (frame * FRAME_PX + v * 800 + h);
  endfunction

  // ---- sync monitor over the first frames ----
  logic mon_en  = 1'b1;
  logic hs_prev = 1'b1;
  logic vs_prev = 1'b1;
  logic hs_seen = 1'b0;
  int   hs_fall = 0, hs_cnt = 0, hs_bad = 0;
  int   vs_fall = 0, vs_cnt = 0, vs_falls = 0, vs_w = 0, vs_t0 = 0, vs_t1 = 0;

  always @(negedge clk) begin
    if (mon_en && cyc >= 4) begin
      hs_prev <= VGA_HS;
      vs_prev <= VGA_VS;
      if (hs_prev && !VGA_HS) begin
        hs_fall <= cyc;
        hs_seen <= 1'b1;
        if (cyc < WIN_END) hs_cnt <= hs_cnt + 1;
      end
      if (!hs_prev && VGA_HS && hs_seen && (cyc - hs_fall != 192)) hs_bad <= hs_bad + 1;
      if (vs_prev && !VGA_VS) begin
        vs_fall  <= cyc;
        vs_falls <= vs_falls + 1;
        if (vs_falls == 0) vs_t0 <= cyc;
        if (vs_falls == 1) vs_t1 <= cyc;
        if (cyc < WIN_END) vs_cnt <= vs_cnt + 1;
      end
      if (!vs_prev && VGA_VS && vs_w == 0 && vs_falls > 0) vs_w <= cyc - vs_fall;
    end
  end

  initial begin
    repeat (2400000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "bench did not finish");
  end

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        blank;
    logic        hs;
    logic        vs;
  } pin_exp_t;

  pin_exp_t tbl[$];

  task automatic add(input int h, input int v, input logic [23:0] rgb,
                     input logic b, input logic hs, input logic vs);
    pin_exp_t e;
    e.h = h; e.v = v; e.rgb = rgb; e.blank = b; e.hs = hs; e.vs = vs;
    tbl.push_back(e);
  endtask

  initial begin
    iReset         = 1'b1;
    wr_bus.x       = '0;
    wr_bus.y       = '0;
    wr_bus.color   = '0;
    wr_bus.writeEn = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst_hs",    VGA_HS, 1);
    check_val("rst_vs",    VGA_VS, 1);
    check_val("rst_vsync", V_SYNC, 1);
    check_val("rst_blank", VGA_BLANK_N, 0);
    check_val("rst_rgb",   {VGA_R, VGA_G, VGA_B}, 0);
    check_val("rst_vclk",  VGA_CLK, 0);
    check_val("sync_n",    VGA_SYNC_N, 0);

    // frame buffer keeps its contents through reset, so load it now
    wr_pix(0, 0, 3'b100);
    wr_pix(319, 239, 3'b011);
    wr_pix(100, 50, 3'b010);
    wr_pix(320, 10, 3'b111);
    wr_pix(5, 240, 3'b111);
    iReset = 1'b0;

    @(negedge clk);
    check_val("vclk_c1", VGA_CLK, 1);
    @(negedge clk);
    check_val("vclk_c2", VGA_CLK, 0);

    // screen positions in scan order: h, v, {R,G,B}, BLANK_N, HS, VS
    add(0,   0,   24'hFF0000, 1, 1, 1);
    add(1,   0,   24'hFF0000, 1, 1, 1);
    add(2,   0,   24'h000000, 1, 1, 1);
    add(640, 0,   24'h000000, 0, 1, 1);
    add(700, 0,   24'h000000, 0, 0, 1);
    add(0,   1,   24'hFF0000, 1, 1, 1);
    add(1,   1,   24'hFF0000, 1, 1, 1);
    add(638, 20,  24'h000000, 1, 1, 1);
    add(0,   22,  24'h000000, 1, 1, 1);
    add(200, 100, 24'h00FF00, 1, 1, 1);
    add(201, 101, 24'h00FF00, 1, 1, 1);
    add(10,  478, 24'h000000, 1, 1, 1);
    add(638, 478, 24'h00FFFF, 1, 1, 1);
    add(639, 478, 24'h00FFFF, 1, 1, 1);
    add(640, 478, 24'h000000, 0, 1, 1);
    add(638, 479, 24'h00FFFF, 1, 1, 1);
    add(639, 479, 24'h00FFFF, 1, 1, 1);
    add(100, 490, 24'h000000, 0, 1, 0);
    add(700, 491, 24'h000000, 0, 0, 0);
    add(0,   492, 24'h000000, 0, 1, 1);

    foreach (tbl[i]) begin
      wait_cyc(pin_cyc(tbl[i].h, tbl[i].v, 0));
      check_val($sformatf("rgb@%0d,%0d", tbl[i].h, tbl[i].v), {VGA_R, VGA_G, VGA_B}, tbl[i].rgb);
      check_val($sformatf("blank@%0d,%0d", tbl[i].h, tbl[i].v), VGA_BLANK_N, tbl[i].blank);
      check_val($sformatf("hs@%0d,%0d", tbl[i].h, tbl[i].v), VGA_HS, tbl[i].hs);
      check_val($sformatf("vs@%0d,%0d", tbl[i].h, tbl[i].v), VGA_VS, tbl[i].vs);
      check_val($sformatf("vsync@%0d,%0d", tbl[i].h, tbl[i].v), V_SYNC, tbl[i].vs);
    end

    // Frame 2: write fb(50,60) during the clk that reads it for screen (100,120)
    wait_cyc(2 * (FRAME_PX + 120 * 800 + 100) + 1);
    wr_pix(50, 60, 3'b101);
    wait_cyc(pin_cyc(100, 120, 1));
    check_val("rdw_old",   {VGA_R, VGA_G, VGA_B}, 24'h000000);
    check_val("rdw_blank", VGA_BLANK_N, 1);
    wait_cyc(pin_cyc(101, 120, 1));
    check_val("rdw_after", {VGA_R, VGA_G, VGA_B}, 24'hFF00FF);
    wait_cyc(pin_cyc(100, 120, 2));
    check_val("rdw_next_frame", {VGA_R, VGA_G, VGA_B}, 24'hFF00FF);

    check_val("hs_pulses", hs_cnt, 525);
    check_val("hs_width_bad", hs_bad, 0);
    check_val("vs_pulses", vs_cnt, 1);
    check_val("vs_width", vs_w, 3200);
    check_val("vs_first_fall", vs_t0, pin_cyc(0, 490, 0));
    check_val("frame_period", vs_t1 - vs_t0, 840000);
    mon_en = 1'b0;

    // Reset for one clk while the counters sit at (400,300) of frame 3
    wait_cyc(2 * (2 * FRAME_PX + 300 * 800 + 400));
    check_val("pre_rst_blank", VGA_BLANK_N, 1);
    iReset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_hs",    VGA_HS, 1);
    check_val("mid_rst_vs",    VGA_VS, 1);
    check_val("mid_rst_blank", VGA_BLANK_N, 0);
    check_val("mid_rst_rgb",   {VGA_R, VGA_G, VGA_B}, 0);
    check_val("mid_rst_vclk",  VGA_CLK, 0);
    iReset = 1'b0;
    @(negedge clk);
    check_val("post_rst_vclk", VGA_CLK, 1);
    wait_cyc(3);
    check_val("post_rst_hs3",    VGA_HS, 1);
    check_val("post_rst_vs3",    VGA_VS, 1);
    check_val("post_rst_blank3", VGA_BLANK_N, 0);
    wait_cyc(4);
    check_val("post_rst_blank4", VGA_BLANK_N, 1);
    check_val("post_rst_rgb4",   {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
